// File: rtl/ram_fifo_pkg.sv
// Shared types and default sizes for the single-port-RAM FIFO controller.
package ram_fifo_pkg;

  localparam int unsigned ADD_WIDTH_DEF  = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_PEND  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_state_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Write-stream and read-stream handshake bundle of ram_fifo_ctrl.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = ram_fifo_pkg::DATA_WIDTH_DEF
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM address pointer with increment enable and async reset.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (inc) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sharing one single-port RAM port between writes and reads.
// Optional sticky overflow output enabled by RAM_FIFO_OVF_FLAG_EN.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned ADD_WIDTH  = ADD_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_fifo_ctrl_if.slave        stream,
  output logic [ADD_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_en,
  output logic [ADD_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RAM_FIFO_OVF_FLAG_EN
  ,
  output logic                  overflow
`endif
);

  localparam int unsigned         DEPTH     = 2 ** ADD_WIDTH;
  localparam logic [ADD_WIDTH:0]  DEPTH_CNT = (ADD_WIDTH + 1)'(DEPTH);

  slot_state_t           slot, slot_next;
  logic                  rd_issue;
  logic                  capture;
  logic                  wr;
  logic [ADD_WIDTH-1:0]  wr_ptr;
  logic [ADD_WIDTH-1:0]  rd_ptr;
  logic [DATA_WIDTH-1:0] din_q;

  ram_fifo_ptr #(.WIDTH(ADD_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr),
    .value (wr_ptr)
  );

  ram_fifo_ptr #(.WIDTH(ADD_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_issue),
    .value (rd_ptr)
  );

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0) && !stream.m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= SLOT_EMPTY;
    end else begin
      slot <= slot_next;
    end
  end

  // rd_issue depends only on registered state, so s_ready has no path from s_valid/m_ready.
  always_comb begin
    slot_next = slot;
    rd_issue  = 1'b0;
    capture   = 1'b0;
    case (slot)
      SLOT_EMPTY: begin
        if (count != '0) begin
          rd_issue  = 1'b1;
          slot_next = SLOT_PEND;
        end
      end
      SLOT_PEND: begin
        capture   = 1'b1;
        slot_next = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (stream.m_ready) begin
          slot_next = SLOT_EMPTY;
        end
      end
      default: slot_next = SLOT_EMPTY;
    endcase
    stream.s_ready = !full && !rd_issue;
    wr             = stream.s_valid && stream.s_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr) begin
      count <= count + (ADD_WIDTH + 1)'(1);
    end else if (rd_issue) begin
      count <= count - (ADD_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= '0;
    end else if (wr) begin
      din_q <= stream.s_data;
    end
  end

  assign ram_en   = wr;
  assign ram_addr = wr ? wr_ptr : rd_ptr;
  assign ram_din  = wr ? stream.s_data : din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream.m_valid <= 1'b0;
      stream.m_data  <= '0;
    end else if (capture) begin
      stream.m_valid <= 1'b1;
      stream.m_data  <= ram_dout;
    end else if (slot == SLOT_FULL && stream.m_ready) begin
      stream.m_valid <= 1'b0;
    end
  end

`ifdef RAM_FIFO_OVF_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if ((stream.s_valid && full) ||
                 (stream.m_ready && !stream.m_valid && empty)) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM model.
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ram_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
`ifdef RAM_FIFO_OVF_FLAG_EN
  logic       overflow;
`endif

  ram_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

  ram_fifo_ctrl #(.ADD_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .stream   (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
`ifdef RAM_FIFO_OVF_FLAG_EN
    ,
    .overflow (overflow)
`endif
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic        sv;
    logic [7:0]  sd;
    logic        mr;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t v(input logic sv, input logic [7:0] sd, input logic mr,
                             input logic sr, input logic en, input logic [3:0] ad,
                             input logic [7:0] di, input logic mv, input logic [7:0] md,
                             input logic [4:0] cn, input logic fu, input logic em);
    vec_t r;
    r.sv  = sv;
    r.sd  = sd;
    r.mr  = mr;
    r.exp = {sr, en, ad, di, mv, md, cn, fu, em};
    return r;
  endfunction

  function automatic logic [29:0] observed();
    return {bus.s_ready, ram_en, ram_addr, ram_din, bus.m_valid, bus.m_data, count, full, empty};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b0;
    exp_q.delete();
    #1;
    check("async reset", 64'({count, bus.m_valid}), 64'd0);
    @(posedge clk);
    cycle_end();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] w);
    logic acc;
    acc         = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = bus.s_ready;
      cycle_end();
    end
    bus.s_valid = 1'b0;
    check("push accept", 64'(acc), 64'd1);
    if (acc) exp_q.push_back(w);
  endtask

  task automatic drain(input string name);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        check(name, 64'(bus.m_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      cycle_end();
    end
    check({name, " left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int         wi;
    int         ri;
    int         acc;
    int         extra;
    logic       seen;
    logic       over;

    rst = 1'b1;
    //                sv    sd     mr    sr    en    ad     din    mv    md     cnt    fu    em
    vecs[0]  = v(1'b1, 8'h3A, 1'b1, 1'b1, 1'b1, 4'd0, 8'h3A, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1);
    vecs[1]  = v(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd0, 8'h3A, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0);
    vecs[2]  = v(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 4'd1, 8'h5A, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1);
    vecs[3]  = v(1'b1, 8'h7A, 1'b1, 1'b1, 1'b1, 4'd2, 8'h7A, 1'b1, 8'h3A, 5'd1, 1'b0, 1'b0);
    vecs[4]  = v(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 8'h7A, 1'b0, 8'h3A, 5'd2, 1'b0, 1'b0);
    vecs[5]  = v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd2, 8'h7A, 1'b0, 8'h3A, 5'd1, 1'b0, 1'b0);
    vecs[6]  = v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd2, 8'h7A, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b0);
    vecs[7]  = v(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 8'h7A, 1'b0, 8'h5A, 5'd1, 1'b0, 1'b0);
    vecs[8]  = v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 8'h7A, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b1);
    vecs[9]  = v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 8'h7A, 1'b1, 8'h7A, 5'd0, 1'b0, 1'b0);
    vecs[10] = v(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 8'h7A, 1'b0, 8'h7A, 5'd0, 1'b0, 1'b1);

    // Three back-to-back words, cycle by cycle.
    do_reset();
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("reset state", 64'(observed()),
          64'({1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1}));
    cycle_end();
    for (int i = 0; i < 11; i++) begin
      bus.s_valid = vecs[i].sv;
      bus.s_data  = vecs[i].sd;
      bus.m_ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(observed()), 64'(vecs[i].exp));
      cycle_end();
    end

    // Fill to full with the consumer stalled, then drain.
    do_reset();
`ifdef RAM_FIFO_OVF_FLAG_EN
    @(negedge clk);
    check("ovf clear", 64'(overflow), 64'd0);
    cycle_end();
`endif
    for (int w = 0; w < 17; w++) push(8'(w));
    repeat (3) cycle_end();
    @(negedge clk);
    check("full state", 64'({count, full, bus.s_ready, bus.m_valid, bus.m_data, empty}),
          64'({5'd16, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0}));
    cycle_end();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("full blocks", 64'({bus.s_ready, ram_en, count}), 64'({1'b0, 1'b0, 5'd16}));
      cycle_end();
    end
    bus.s_valid = 1'b0;
`ifdef RAM_FIFO_OVF_FLAG_EN
    repeat (2) cycle_end();
    @(negedge clk);
    check("ovf sticky", 64'(overflow), 64'd1);
    cycle_end();
`endif
    drain("full drain");
    @(negedge clk);
    check("empty after drain", 64'({empty, count}), 64'({1'b1, 5'd0}));
    cycle_end();

    // 40 words with random consumer back-pressure; pointers wrap twice.
    do_reset();
    wi   = 0;
    ri   = 0;
    over = 1'b0;
    for (int c = 0; c < 2000 && ri < 40; c++) begin
      bus.s_valid = (wi < 40);
      bus.s_data  = 8'h80 + 8'(wi);
      bus.m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (count > 5'd16) over = 1'b1;
      if (bus.s_valid && bus.s_ready) wi++;
      if (bus.m_valid && bus.m_ready) begin
        check("wrap data", 64'(bus.m_data), 64'(8'h80 + 8'(ri)));
        ri++;
      end
      cycle_end();
    end
    bus.s_valid = 1'b0;
    check("wrap words", 64'(ri), 64'd40);
    check("count range", 64'(over), 64'd0);

    // Output stall: m_data stable, writes continue.
    do_reset();
    push(8'h5A);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.m_valid;
      cycle_end();
    end
    check("stall valid", 64'(seen), 64'd1);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h60 + 8'(acc);
      @(negedge clk);
      check("stall hold", 64'({bus.m_valid, bus.m_data}), 64'({1'b1, 8'h5A}));
      if (bus.s_ready) begin
        exp_q.push_back(bus.s_data);
        acc++;
      end
      cycle_end();
    end
    bus.s_valid = 1'b0;
    check("stall writes", 64'(acc), 64'd10);
    drain("stall drain");

    // Reset while count=5 and a read is pending.
    do_reset();
    for (int w = 0; w < 7; w++) push(8'hC0 + 8'(w));
    @(negedge clk);
    check("pre pend", 64'({count, bus.m_valid}), 64'({5'd6, 1'b1}));
    cycle_end();
    bus.m_ready = 1'b1;
    cycle_end();
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("rd issue", 64'({count, ram_en, bus.s_ready, ram_addr}),
          64'({5'd6, 1'b0, 1'b0, 4'd1}));
    cycle_end();
    @(negedge clk);
    check("pend", 64'({count, bus.m_valid}), 64'({5'd5, 1'b0}));
    #2;
    rst = 1'b1;
    #1;
    check("mid reset", 64'({count, bus.m_valid, full, empty, ram_addr}),
          64'({5'd0, 1'b0, 1'b0, 1'b1, 4'd0}));
    cycle_end();
    rst = 1'b0;
    exp_q.delete();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    @(negedge clk);
    check("post reset write", 64'({bus.s_ready, ram_en, ram_addr, ram_din}),
          64'({1'b1, 1'b1, 4'd0, 8'hA5}));
`ifdef RAM_FIFO_OVF_FLAG_EN
    check("ovf reset", 64'(overflow), 64'd0);
`endif
    cycle_end();
    bus.s_valid = 1'b0;
    exp_q.push_back(8'hA5);
    drain("post reset drain");
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_valid) extra++;
      cycle_end();
    end
    check("no stale words", 64'(extra), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
